// File: rtl/sd_image_loader.sv
// ============================================================================
// Module   : sd_image_loader
// Sequences multi-sector SD reads and packs the byte stream into frame RAM pixels.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sd_image_loader #(
   parameter int NUM_IMAGES       = 4,
   parameter int PIXELS_PER_IMAGE = 76800,
   parameter int PIXEL_BYTES      = 2,
   parameter int BASE_SECTOR      = 0,
   parameter int ADDR_W           = 17,
   parameter int TIMEOUT_CYCLES   = 1000000,
   parameter int IDX_W            = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     load_req,
   input  logic [IDX_W-1:0]         img_idx,
   input  logic                     abort,
   output logic                     sd_start_read,
   output logic [31:0]              sd_sector_addr,
   input  logic [7:0]               sd_data_in,
   input  logic                     sd_data_valid,
   output logic                     ram_we,
   output logic [ADDR_W-1:0]        ram_addr,
   output logic [8*PIXEL_BYTES-1:0] ram_wdata,
   output logic                     busy,
   output logic                     done,
   output logic                     error,
   output logic [IDX_W-1:0]         active_img
);

   localparam int SECTORS_PER_IMAGE = (PIXELS_PER_IMAGE * PIXEL_BYTES + 511) / 512;
   localparam int LANE_W = (PIXEL_BYTES > 1) ? $clog2(PIXEL_BYTES) : 1;
   localparam int PCNT_W = ADDR_W + 1;
   localparam int DATA_W = 8 * PIXEL_BYTES;

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_RECV, S_NEXT, S_DONE, S_ERR
   } state_t;

   state_t              state, state_nx;
   logic [IDX_W-1:0]    idx_q;
   logic [31:0]         sector_cnt;
   logic [31:0]         tcnt;
   logic [8:0]          byte_cnt;
   logic [PCNT_W-1:0]   pix_cnt;
   logic [LANE_W-1:0]   lane;
   logic [DATA_W-1:0]   pix_q;
   logic [DATA_W-1:0]   pix_merged;
   logic                idx_ok;
   logic                accept_byte;
   logic                last_lane;
   logic                pix_room;
   logic                last_sector;

   assign idx_ok      = 32'(img_idx) < 32'(NUM_IMAGES);
   assign accept_byte = (state == S_RECV) && sd_data_valid && !abort;
   assign last_lane   = lane == LANE_W'(PIXEL_BYTES - 1);
   assign pix_room    = pix_cnt < PCNT_W'(PIXELS_PER_IMAGE);
   assign last_sector = sector_cnt == 32'(SECTORS_PER_IMAGE - 1);

   // Incoming byte merged into its lane of the partially assembled pixel.
   always_comb begin
      pix_merged = pix_q;
      pix_merged[int'(lane) * 8 +: 8] = sd_data_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx      = state;
      sd_start_read = 1'b0;
      done          = 1'b0;
      error         = 1'b0;
      busy          = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (load_req) state_nx = idx_ok ? S_START : S_ERR;
         end
         S_START: begin
            sd_start_read = 1'b1;
            state_nx      = abort ? S_ERR : S_RECV;
         end
         S_RECV: begin
            if (abort)
               state_nx = S_ERR;
            else if (sd_data_valid && byte_cnt == 9'd511)
               state_nx = last_sector ? S_DONE : S_NEXT;
            else if (!sd_data_valid && tcnt == 32'(TIMEOUT_CYCLES - 1))
               state_nx = S_ERR;
         end
         S_NEXT: begin
            state_nx = abort ? S_ERR : S_START;
         end
         S_DONE: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         S_ERR: begin
            error    = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q          <= '0;
         sector_cnt     <= '0;
         tcnt           <= '0;
         byte_cnt       <= '0;
         pix_cnt        <= '0;
         lane           <= '0;
         pix_q          <= '0;
         sd_sector_addr <= '0;
         ram_we         <= 1'b0;
         ram_addr       <= '0;
         ram_wdata      <= '0;
         active_img     <= '0;
      end else begin
         ram_we <= 1'b0;
         case (state)
            S_IDLE: begin
               if (load_req && idx_ok) begin
                  idx_q          <= img_idx;
                  sector_cnt     <= '0;
                  byte_cnt       <= '0;
                  pix_cnt        <= '0;
                  lane           <= '0;
                  pix_q          <= '0;
                  sd_sector_addr <= 32'(BASE_SECTOR) + 32'(img_idx) * 32'(SECTORS_PER_IMAGE);
               end
            end
            S_START: tcnt <= '0;
            S_RECV: begin
               if (accept_byte) begin
                  tcnt     <= '0;
                  byte_cnt <= byte_cnt + 9'd1;
                  // Padding bytes past the last pixel are consumed without touching lanes.
                  if (pix_room) begin
                     if (last_lane) begin
                        ram_we    <= 1'b1;
                        ram_addr  <= pix_cnt[ADDR_W-1:0];
                        ram_wdata <= pix_merged;
                        pix_cnt   <= pix_cnt + PCNT_W'(1);
                        lane      <= '0;
                     end else begin
                        pix_q <= pix_merged;
                        lane  <= lane + LANE_W'(1);
                     end
                  end
               end else if (!sd_data_valid) begin
                  tcnt <= tcnt + 32'd1;
               end
            end
            S_NEXT: begin
               sector_cnt     <= sector_cnt + 32'd1;
               byte_cnt       <= '0;
               sd_sector_addr <= sd_sector_addr + 32'd1;
            end
            S_DONE: active_img <= idx_q;
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sd_image_loader.sv
// Bench for sd_image_loader: two instances (2-byte and 3-byte pixels), SD reader
// stand-in, and a queue model of expected sector requests and RAM writes.
`timescale 1ns/1ps
`default_nettype none

module tb_sd_image_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic        load_a, abort_a, valid_a;
   logic [1:0]  idx_a;
   logic [7:0]  din_a;
   logic        start_a, we_a, busy_a, done_a, err_a;
   logic [31:0] sec_a;
   logic [8:0]  addr_a;
   logic [15:0] wd_a;
   logic [1:0]  act_a;

   logic        load_b, abort_b, valid_b;
   logic [2:0]  idx_b;
   logic [7:0]  din_b;
   logic        start_b, we_b, busy_b, done_b, err_b;
   logic [31:0] sec_b;
   logic [8:0]  addr_b;
   logic [23:0] wd_b;
   logic [2:0]  act_b;

   sd_image_loader #(.NUM_IMAGES(4), .PIXELS_PER_IMAGE(300), .PIXEL_BYTES(2),
      .BASE_SECTOR(100), .ADDR_W(9), .TIMEOUT_CYCLES(50)) u_a (
      .clk(clk), .rst_n(rst_n), .load_req(load_a), .img_idx(idx_a), .abort(abort_a),
      .sd_start_read(start_a), .sd_sector_addr(sec_a), .sd_data_in(din_a),
      .sd_data_valid(valid_a), .ram_we(we_a), .ram_addr(addr_a), .ram_wdata(wd_a),
      .busy(busy_a), .done(done_a), .error(err_a), .active_img(act_a));

   sd_image_loader #(.NUM_IMAGES(5), .PIXELS_PER_IMAGE(300), .PIXEL_BYTES(3),
      .BASE_SECTOR(0), .ADDR_W(9), .TIMEOUT_CYCLES(50)) u_b (
      .clk(clk), .rst_n(rst_n), .load_req(load_b), .img_idx(idx_b), .abort(abort_b),
      .sd_start_read(start_b), .sd_sector_addr(sec_b), .sd_data_in(din_b),
      .sd_data_valid(valid_b), .ram_we(we_b), .ram_addr(addr_b), .ram_wdata(wd_b),
      .busy(busy_b), .done(done_b), .error(err_b), .active_img(act_b));

   typedef struct {
      int          addr;
      logic [23:0] data;
      int          cyc;
   } wr_t;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   wr_t         qa[$], qb[$];
   int          sqa[$], sqb[$];
   int          nwr[2];
   int          nstart[2];
   int          kpos[2];
   logic [23:0] acc[2];
   logic [23:0] mem_a[512];
   logic [23:0] mem_b[512];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h required=%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic fail_now(string name);
      checks++;
      failures++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   function automatic logic [7:0] bval(int k);
      if (k == 0) return 8'h34;
      if (k == 1) return 8'h12;
      return 8'((k * 13 + 5) & 255);
   endfunction

   function automatic int pbytes(int i);
      return (i == 0) ? 2 : 3;
   endfunction

   function automatic int base_sec(int i);
      return (i == 0) ? 100 : 0;
   endfunction

   function automatic bit st(int i);  return (i == 0) ? start_a : start_b; endfunction
   function automatic bit dn(int i);  return (i == 0) ? done_a  : done_b;  endfunction
   function automatic bit er(int i);  return (i == 0) ? err_a   : err_b;   endfunction
   function automatic bit bz(int i);  return (i == 0) ? busy_a  : busy_b;  endfunction
   function automatic int act(int i); return (i == 0) ? int'(act_a) : int'(act_b); endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(int i, bit v, logic [7:0] d, bit ab);
      if (i == 0) begin valid_a = v; din_a = d; abort_a = ab; end
      else        begin valid_b = v; din_b = d; abort_b = ab; end
   endtask

   task automatic set_load(int i, bit l, int img);
      if (i == 0) begin load_a = l; idx_a = 2'(img); end
      else        begin load_b = l; idx_b = 3'(img); end
   endtask

   task automatic push_wr(int i, int addr, logic [23:0] data, int c);
      wr_t e;
      e.addr = addr; e.data = data; e.cyc = c;
      if (i == 0) qa.push_back(e);
      else        qb.push_back(e);
   endtask

   // Two sectors per image for both instances (600 and 900 bytes).
   task automatic start_load(int i, int img);
      kpos[i] = 0;
      acc[i]  = '0;
      for (int s = 0; s < 2; s++) begin
         if (i == 0) sqa.push_back(base_sec(i) + img * 2 + s);
         else        sqb.push_back(base_sec(i) + img * 2 + s);
      end
      set_load(i, 1'b1, img);
      step();
      set_load(i, 1'b0, img);
   endtask

   task automatic wait_start(int i, output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 10; t++) begin
         if (st(i)) begin ok = 1'b1; break; end
         step();
      end
      if (!ok) fail_now("start_read_timeout");
   endtask

   task automatic wait_flag(int i, bit is_err, int max, output bit ok, output int n);
      ok = 1'b0;
      n  = 0;
      for (int t = 0; t <= max; t++) begin
         if (is_err ? er(i) : dn(i)) begin ok = 1'b1; break; end
         step();
         n++;
      end
   endtask

   // Byte k of the image lands in lane k%PB of pixel k/PB; a write is due the
   // cycle after the byte that completes a pixel, unless aborted or padding.
   task automatic send_bytes(int i, int n, bit abort_last, bit gaps);
      logic [7:0] b;
      bit         ab;
      for (int j = 0; j < n; j++) begin
         b  = bval(kpos[i]);
         ab = abort_last && (j == n - 1);
         drive(i, 1'b1, b, ab);
         acc[i] = acc[i] | (24'(b) << (8 * (kpos[i] % pbytes(i))));
         if (kpos[i] % pbytes(i) == pbytes(i) - 1) begin
            if (!ab && kpos[i] / pbytes(i) < 300)
               push_wr(i, kpos[i] / pbytes(i), acc[i], cyc + 1);
            acc[i] = '0;
         end
         kpos[i]++;
         step();
         drive(i, 1'b0, 8'h00, 1'b0);
         if (gaps && (j % 37 == 36)) step();
      end
   endtask

   task automatic load_full(int i, int img);
      bit ok;
      int n;
      start_load(i, img);
      for (int s = 0; s < 2; s++) begin
         wait_start(i, ok);
         if (!ok) return;
         step();
         send_bytes(i, 512, 1'b0, 1'b1);
      end
      wait_flag(i, 1'b0, 3, ok, n);
      chk("done_pulse", ok, 1);
      chk("done_latency", n, 0);
      step();
      chk("done_one_cycle", dn(i), 0);
      chk("busy_after_done", bz(i), 0);
      chk("active_img_after_done", act(i), img);
   endtask

   always @(negedge clk) begin
      wr_t e;
      if (rst_n) begin
         if (we_a) begin
            nwr[0]++;
            mem_a[addr_a] = {8'h00, wd_a};
            if (qa.size() == 0) fail_now("unexpected_write_a");
            else begin
               e = qa.pop_front();
               chk("wr_addr_a", addr_a, e.addr);
               chk("wr_data_a", wd_a, e.data);
               chk("wr_cycle_a", cyc, e.cyc);
            end
         end else if (qa.size() > 0 && qa[0].cyc < cyc) begin
            fail_now("missing_write_a");
            void'(qa.pop_front());
         end
         if (we_b) begin
            nwr[1]++;
            mem_b[addr_b] = wd_b;
            if (qb.size() == 0) fail_now("unexpected_write_b");
            else begin
               e = qb.pop_front();
               chk("wr_addr_b", addr_b, e.addr);
               chk("wr_data_b", wd_b, e.data);
               chk("wr_cycle_b", cyc, e.cyc);
            end
         end else if (qb.size() > 0 && qb[0].cyc < cyc) begin
            fail_now("missing_write_b");
            void'(qb.pop_front());
         end
         if (start_a) begin
            nstart[0]++;
            if (sqa.size() == 0) fail_now("unexpected_start_read_a");
            else chk("sector_addr_a", sec_a, sqa.pop_front());
         end
         if (start_b) begin
            nstart[1]++;
            if (sqb.size() == 0) fail_now("unexpected_start_read_b");
            else chk("sector_addr_b", sec_b, sqb.pop_front());
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog_expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int n, w0, s0;
      nwr = '{0, 0};
      nstart = '{0, 0};
      rst_n = 1'b0;
      drive(0, 1'b0, 8'h00, 1'b0);
      drive(1, 1'b0, 8'h00, 1'b0);
      set_load(0, 1'b0, 0);
      set_load(1, 1'b0, 0);
      repeat (3) step();
      chk("rst_outputs_a", {start_a, sec_a, we_a, addr_a, wd_a, busy_a, done_a, err_a, act_a}, 0);
      chk("rst_outputs_b", {start_b, sec_b, we_b, addr_b, wd_b, busy_b, done_b, err_b, act_b}, 0);
      rst_n = 1'b1;
      step();

      // Image 2, 16-bit pixels: sectors 104/105, 300 writes, padding ignored.
      w0 = nwr[0];
      load_full(0, 2);
      chk("t1_write_count", nwr[0] - w0, 300);
      chk("t1_pixel0", mem_a[0], 24'h001234);
      chk("t1_pixel299", mem_a[299], 24'h007063);

      // 24-bit pixels: pixel 170 straddles the sector boundary.
      w0 = nwr[1];
      load_full(1, 1);
      chk("t2_write_count", nwr[1] - w0, 300);
      chk("t2_pixel170", mem_b[170], 24'h05F8EB);

      // Out-of-range index.
      s0 = nstart[1];
      set_load(1, 1'b1, 5);
      step();
      set_load(1, 1'b0, 0);
      wait_flag(1, 1'b1, 2, ok, n);
      chk("t3_error_pulse", ok, 1);
      step();
      chk("t3_busy_low", busy_b, 0);
      chk("t3_active_unchanged", act_b, 1);
      chk("t3_no_start_read", nstart[1] - s0, 0);

      // Stall after 10 bytes.
      w0 = nwr[0];
      start_load(0, 1);
      wait_start(0, ok);
      step();
      send_bytes(0, 10, 1'b0, 1'b0);
      wait_flag(0, 1'b1, 60, ok, n);
      chk("t4_timeout_seen", ok, 1);
      chk("t4_timeout_cycles", n, 50);
      sqa.delete();
      step();
      chk("t4_busy_low", busy_a, 0);
      chk("t4_active_unchanged", act_a, 2);
      chk("t4_write_count", nwr[0] - w0, 5);
      load_full(0, 3);

      // Abort coincident with the 200th byte (completes pixel 99).
      w0 = nwr[0];
      start_load(0, 0);
      wait_start(0, ok);
      step();
      send_bytes(0, 200, 1'b1, 1'b0);
      wait_flag(0, 1'b1, 2, ok, n);
      chk("t5_error_pulse", ok, 1);
      sqa.delete();
      s0 = nstart[0];
      repeat (20) step();
      chk("t5_no_more_start_read", nstart[0] - s0, 0);
      chk("t5_write_count", nwr[0] - w0, 99);
      chk("t5_active_unchanged", act_a, 3);

      // Asynchronous reset in the middle of a sector.
      start_load(0, 2);
      wait_start(0, ok);
      step();
      send_bytes(0, 100, 1'b0, 1'b0);
      step();
      #1 rst_n = 1'b0;
      #1;
      chk("t6_async_reset_a", {start_a, sec_a, we_a, addr_a, wd_a, busy_a, done_a, err_a, act_a}, 0);
      sqa.delete();
      chk("t6_no_pending_writes", qa.size(), 0);
      qa.delete();
      step();
      rst_n = 1'b1;
      step();
      load_full(0, 0);

      chk("end_writes_a_drained", qa.size(), 0);
      chk("end_writes_b_drained", qb.size(), 0);
      chk("end_sectors_drained", sqa.size() + sqb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
